rng_sample_sched: RTL and testbench



---
 rtl/rng_sched_pkg.sv | 33 +++
 rtl/rng_word_fifo.sv | 60 ++++++
 rtl/rng_sample_sched.sv | 231 +++++++++++++++++++++++
 tb/tb_rng_sample_sched.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_sched_pkg.sv
// Shared types and constants for the chaos-RNG sample scheduler.
package rng_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    COLLECT = 2'd2,
    FAULT   = 2'd3
  } sched_state_e;

  localparam int REQ_WB = 0;
  localparam int REQ_IO = 1;

  localparam int DEF_WORD_W      = 32;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_WARMUP_BITS = 64;
  localparam int DEF_RCT_LIMIT   = 16;

  // Round-robin pick between the two requesters; on contention the one
  // that was not served last wins, otherwise whoever is eligible wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] elig,
                                         input logic       last_io);
    logic [1:0] g;
    g = elig;
    if (elig[REQ_WB] && elig[REQ_IO]) begin
      g = '0;
      if (last_io) g[REQ_WB] = 1'b1;
      else         g[REQ_IO] = 1'b1;
    end
    return g;
  endfunction

endpackage

// File: rtl/rng_word_fifo.sv
// Small synchronous word FIFO with flush, level output and same-cycle
// push/pop (a pop frees the slot so a push is accepted even when full).
module rng_word_fifo
  import rng_sched_pkg::*;
#(
  parameter  int WIDTH = DEF_WORD_W,
  parameter  int DEPTH = DEF_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [LVL_W-1:0] level,
  output logic             empty,
  output logic             full
);

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty    = (level == '0);
  assign full     = (level == FULL_LVL);
  assign rd_en    = pop && !empty;
  assign wr_en    = push && (!full || rd_en);
  assign pop_data = mem[rd_ptr];

  // Storage array; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; flush empties the queue in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !rd_en)      level <= level + 1'b1;
      else if (rd_en && !wr_en) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/rng_sample_sched.sv
// Sequencer for the chaos entropy core: warm-up, bit packing, repetition
// count health test, word buffering and round-robin sharing between the
// Wishbone read path and the IO stream.
module rng_sample_sched
  import rng_sched_pkg::*;
#(
  parameter  int WORD_W      = DEF_WORD_W,
  parameter  int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter  int WARMUP_BITS = DEF_WARMUP_BITS,
  parameter  int RCT_LIMIT   = DEF_RCT_LIMIT,
  localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              bit_valid_i,
  input  logic              bit_i,
  output logic              core_run_o,
  input  logic [1:0]        req_i,
  output logic [1:0]        gnt_o,
  output logic [WORD_W-1:0] data_o,
  output logic [LVL_W-1:0]  fifo_level_o,
  output logic              health_fail_o,
  output logic              irq_o
);

  localparam int IDX_W  = $clog2(WORD_W);
  localparam int WARM_W = $clog2(WARMUP_BITS + 1);
  localparam int RUN_W  = $clog2(RCT_LIMIT + 1);

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WORD_W - 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_BITS - 1);
  localparam logic [RUN_W-1:0]  RUN_TRIP  = RUN_W'(RCT_LIMIT);
  localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

  sched_state_e      state;
  logic [WARM_W-1:0] warm_cnt;

  logic [IDX_W-1:0]  bit_idx;
  logic [WORD_W-1:0] word_reg;
  logic [WORD_W-1:0] packed_word;
  logic [WORD_W-1:0] push_data;
  logic              word_pend;
  logic [RUN_W-1:0]  run_cnt;
  logic [RUN_W-1:0]  run_nxt;
  logic              last_bit;
  logic              last_gnt_io;

  logic              in_collect;
  logic              accept;
  logic              word_done;
  logic              trip;
  logic              block;
  logic              can_push;
  logic              push_last;
  logic              push_pend;
  logic              push;
  logic              pop;
  logic              flush;
  logic              health_nxt;
  logic [1:0]        elig;
  logic [1:0]        grant_nxt;
  logic [LVL_W-1:0]  level_nxt;

  logic [WORD_W-1:0] fifo_head;
  logic              fifo_empty;
  logic              fifo_full;

  // Bit acceptance, word assembly and repetition-count evaluation.
  always_comb begin
    in_collect  = (state == COLLECT) && en_i;
    accept      = in_collect && bit_valid_i && !word_pend;
    packed_word = word_reg;
    packed_word[bit_idx] = bit_i;
    if (run_cnt == '0 || bit_i != last_bit) run_nxt = RUN_ONE;
    else                                    run_nxt = run_cnt + 1'b1;
    trip      = accept && (run_nxt == RUN_TRIP);
    word_done = accept && (bit_idx == IDX_LAST);
  end

  // Arbitration: a requester granted last cycle sits out one cycle, and
  // nothing is granted while the health test is tripping or tripped.
  always_comb begin
    block     = (state == FAULT) || trip;
    elig      = req_i & ~gnt_o & {2{!fifo_empty && !block}};
    grant_nxt = rr_pick(elig, last_gnt_io);
    pop       = |grant_nxt;
  end

  // Push decision and next-cycle occupancy so irq_o tracks the level.
  always_comb begin
    can_push   = !fifo_full || pop;
    push_last  = word_done && !trip && can_push;
    push_pend  = in_collect && word_pend && can_push;
    push       = push_last || push_pend;
    push_data  = word_pend ? word_reg : packed_word;
    flush      = trip || (state == FAULT);
    health_nxt = trip || (health_fail_o && !((state == FAULT) && clr_i));
    level_nxt  = fifo_level_o;
    if (flush)              level_nxt = '0;
    else if (push && !pop)  level_nxt = fifo_level_o + 1'b1;
    else if (pop && !push)  level_nxt = fifo_level_o - 1'b1;
  end

  // Main sequencer with registered core run enable and sticky fault flag.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state         <= IDLE;
      warm_cnt      <= '0;
      core_run_o    <= 1'b0;
      health_fail_o <= 1'b0;
    end else begin
      health_fail_o <= health_nxt;
      case (state)
        IDLE: begin
          core_run_o <= 1'b0;
          if (en_i) begin
            state      <= WARMUP;
            warm_cnt   <= '0;
            core_run_o <= 1'b1;
          end
        end
        WARMUP: begin
          if (!en_i) begin
            state      <= IDLE;
            core_run_o <= 1'b0;
          end else if (bit_valid_i) begin
            if (warm_cnt == WARM_LAST) state <= COLLECT;
            else                       warm_cnt <= warm_cnt + 1'b1;
          end
        end
        COLLECT: begin
          if (!en_i) begin
            state      <= IDLE;
            core_run_o <= 1'b0;
          end else if (trip) begin
            state      <= FAULT;
            core_run_o <= 1'b0;
          end else if (word_done && !can_push) begin
            core_run_o <= 1'b0;
          end else if (push_pend) begin
            core_run_o <= 1'b1;
          end
        end
        FAULT: begin
          core_run_o <= 1'b0;
          if (clr_i) state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          core_run_o <= 1'b0;
        end
      endcase
    end
  end

  // Packer and run counter; everything is dropped whenever collection stops.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      bit_idx   <= '0;
      word_reg  <= '0;
      word_pend <= 1'b0;
      run_cnt   <= '0;
      last_bit  <= 1'b0;
    end else if (!in_collect) begin
      bit_idx   <= '0;
      word_reg  <= '0;
      word_pend <= 1'b0;
      run_cnt   <= '0;
      last_bit  <= 1'b0;
    end else if (accept) begin
      run_cnt  <= run_nxt;
      last_bit <= bit_i;
      if (word_done) begin
        bit_idx <= '0;
        if (can_push) begin
          word_reg <= '0;
        end else begin
          word_reg  <= packed_word;
          word_pend <= 1'b1;
        end
      end else begin
        bit_idx  <= bit_idx + 1'b1;
        word_reg <= packed_word;
      end
    end else if (push_pend) begin
      word_pend <= 1'b0;
      word_reg  <= '0;
    end
  end

  // Registered grant pulse and data; data_o keeps the last granted word.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      gnt_o       <= '0;
      data_o      <= '0;
      last_gnt_io <= 1'b1;
    end else begin
      gnt_o <= grant_nxt;
      if (pop) begin
        data_o      <= fifo_head;
        last_gnt_io <= grant_nxt[REQ_IO];
      end
    end
  end

  // Level interrupt: buffer full or health failure.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) irq_o <= 1'b0;
    else            irq_o <= (level_nxt == LVL_FULL) || health_nxt;
  end

  rng_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_ni),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .level     (fifo_level_o),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_rng_sample_sched.sv
// Directed bench for rng_sample_sched: table-driven cycle vectors plus
// hand-written warm-up / packing / fault / reset sequences.
module tb_rng_sample_sched;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni;
  logic        en_i;
  logic        clr_i;
  logic        bit_valid_i;
  logic        bit_i;
  logic        core_run_o;
  logic [1:0]  req_i;
  logic [1:0]  gnt_o;
  logic [31:0] data_o;
  logic [2:0]  fifo_level_o;
  logic        health_fail_o;
  logic        irq_o;

  int vec_count;
  int miss_count;

  typedef struct {
    logic        en;
    logic        clr;
    logic        bv;
    logic        b;
    logic [1:0]  req;
    logic        core;
    logic [1:0]  gnt;
    logic [31:0] data;
    logic [2:0]  level;
    logic        health;
    logic        irq;
  } vec_t;

  vec_t tbl[$];

  localparam logic [31:0] W1  = 32'h12345678;
  localparam logic [31:0] W2  = 32'hCAFEBABE;
  localparam logic [31:0] W3  = 32'h0F0F0F0F;
  localparam logic [31:0] W4  = 32'h5A5A5A5A;
  localparam logic [31:0] W5  = 32'h3C3C3C3C;
  localparam logic [31:0] W6  = 32'h11223344;
  localparam logic [31:0] W7  = 32'h99887766;
  localparam logic [31:0] W8  = 32'h600DF00D;
  localparam logic [31:0] W9  = 32'h0F0F0F0F;
  localparam logic [31:0] W10 = 32'hDEADBEEF;

  always #5 wb_clk_i = ~wb_clk_i;

  rng_sample_sched #(
    .WORD_W      (32),
    .FIFO_DEPTH  (4),
    .WARMUP_BITS (64),
    .RCT_LIMIT   (16)
  ) dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_ni     (wb_rst_ni),
    .en_i          (en_i),
    .clr_i         (clr_i),
    .bit_valid_i   (bit_valid_i),
    .bit_i         (bit_i),
    .core_run_o    (core_run_o),
    .req_i         (req_i),
    .gnt_o         (gnt_o),
    .data_o        (data_o),
    .fifo_level_o  (fifo_level_o),
    .health_fail_o (health_fail_o),
    .irq_o         (irq_o)
  );

  task automatic applyStimulus(input logic en, input logic clr, input logic bv,
                               input logic b, input logic [1:0] req);
    @(negedge wb_clk_i);
    en_i        = en;
    clr_i       = clr;
    bit_valid_i = bv;
    bit_i       = b;
    req_i       = req;
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic core, input logic [1:0] gnt,
                          input logic [31:0] data, input logic [2:0] lvl,
                          input logic health, input logic irq);
    checkOutput({tag, " core_run"}, 32'(core_run_o), 32'(core));
    checkOutput({tag, " gnt"}, 32'(gnt_o), 32'(gnt));
    checkOutput({tag, " data"}, data_o, data);
    checkOutput({tag, " level"}, 32'(fifo_level_o), 32'(lvl));
    checkOutput({tag, " health"}, 32'(health_fail_o), 32'(health));
    checkOutput({tag, " irq"}, 32'(irq_o), 32'(irq));
  endtask

  function automatic vec_t mk(input logic en, input logic clr, input logic bv,
                              input logic b, input logic [1:0] req,
                              input logic core, input logic [1:0] gnt,
                              input logic [31:0] data, input logic [2:0] level,
                              input logic health, input logic irq);
    vec_t v;
    v.en = en; v.clr = clr; v.bv = bv; v.b = b; v.req = req;
    v.core = core; v.gnt = gnt; v.data = data; v.level = level;
    v.health = health; v.irq = irq;
    return v;
  endfunction

  task automatic runTable(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].en, tbl[i].clr, tbl[i].bv, tbl[i].b, tbl[i].req);
      checkAll($sformatf("%s[%0d]", tag, i), tbl[i].core, tbl[i].gnt,
               tbl[i].data, tbl[i].level, tbl[i].health, tbl[i].irq);
    end
    tbl.delete();
  endtask

  task automatic feedWord(input logic [31:0] w);
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b0, 1'b1, w[i], 2'b00);
  endtask

  task automatic feedAlt(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b1, i[0], 2'b00);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] w;
    vec_count   = 0;
    miss_count  = 0;
    wb_rst_ni   = 1'b0;
    en_i        = 1'b0;
    clr_i       = 1'b0;
    bit_valid_i = 1'b0;
    bit_i       = 1'b0;
    req_i       = 2'b00;

    #12;
    checkAll("reset", 1'b0, 2'b00, 32'h0, 3'd0, 1'b0, 1'b0);
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;

    // Warm-up then first word from alternating bits.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    checkOutput("warmup core_run", 32'(core_run_o), 32'd1);
    feedAlt(64);
    w = 32'hAAAAAAAA;
    for (int i = 0; i < 31; i++) applyStimulus(1'b1, 1'b0, 1'b1, w[i], 2'b00);
    checkOutput("level before last bit", 32'(fifo_level_o), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, w[31], 2'b00);
    checkAll("first word", 1'b1, 2'b00, 32'h0, 3'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
    checkAll("wb grant", 1'b1, 2'b01, 32'hAAAAAAAA, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    checkAll("data hold", 1'b1, 2'b00, 32'hAAAAAAAA, 3'd0, 1'b0, 1'b0);

    // Fill the FIFO, then a fifth word is held with the core stopped.
    feedWord(W1);
    feedWord(W2);
    feedWord(W3);
    checkAll("three words", 1'b1, 2'b00, 32'hAAAAAAAA, 3'd3, 1'b0, 1'b0);
    feedWord(W4);
    checkAll("fifo full", 1'b1, 2'b00, 32'hAAAAAAAA, 3'd4, 1'b0, 1'b1);
    feedWord(W5);
    checkAll("word held", 1'b0, 2'b00, 32'hAAAAAAAA, 3'd4, 1'b0, 1'b1);

    // Held word pushes on a grant, then round-robin drain with req 11.
    tbl.push_back(mk(1, 0, 1, 1, 2'b00, 0, 2'b00, 32'hAAAAAAAA, 3'd4, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 2'b10, 1, 2'b10, W1, 3'd4, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 2'b00, 1, 2'b00, W1, 3'd4, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 2'b11, 1, 2'b01, W2, 3'd3, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 2'b11, 1, 2'b10, W3, 3'd2, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 2'b11, 1, 2'b01, W4, 3'd1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 2'b11, 1, 2'b10, W5, 3'd0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 2'b11, 1, 2'b00, W5, 3'd0, 0, 0));
    runTable("rr");

    // Disable mid-word with two words buffered.
    feedWord(W6);
    feedWord(W7);
    checkAll("two words", 1'b1, 2'b00, W5, 3'd2, 1'b0, 1'b0);
    feedAlt(10);
    checkOutput("partial level", 32'(fifo_level_o), 32'd2);
    tbl.push_back(mk(0, 0, 1, 1, 2'b00, 0, 2'b00, W5, 3'd2, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 2'b01, 0, 2'b01, W6, 3'd1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2'b10, 0, 2'b10, W7, 3'd0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2'b11, 0, 2'b00, W7, 3'd0, 0, 0));
    runTable("endrop");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    checkOutput("rewarm core_run", 32'(core_run_o), 32'd1);
    feedAlt(64);
    feedWord(W8);
    checkAll("rewarm word", 1'b1, 2'b00, W7, 3'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
    checkAll("partial lost", 1'b1, 2'b01, W8, 3'd0, 1'b0, 1'b0);

    // Repetition-count fault, clear outside FAULT ignored.
    feedWord(W9);
    checkAll("pre-fault", 1'b1, 2'b00, W8, 3'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    checkAll("clr ignored", 1'b1, 2'b00, W8, 3'd1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 2'b00);
    checkAll("15 ones", 1'b1, 2'b00, W8, 3'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 2'b00);
    checkAll("rct trip", 1'b0, 2'b00, W8, 3'd0, 1'b1, 1'b1);
    tbl.push_back(mk(1, 0, 1, 1, 2'b11, 0, 2'b00, W8, 3'd0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 2'b11, 0, 2'b00, W8, 3'd0, 1, 1));
    tbl.push_back(mk(1, 1, 0, 0, 2'b00, 0, 2'b00, W8, 3'd0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 2'b00, 1, 2'b00, W8, 3'd0, 0, 0));
    runTable("fault");
    feedAlt(64);
    feedWord(W10);
    checkAll("after clear", 1'b1, 2'b00, W8, 3'd1, 1'b0, 1'b0);

    // Asynchronous reset with a grant about to be issued.
    @(negedge wb_clk_i);
    en_i        = 1'b1;
    bit_valid_i = 1'b0;
    req_i       = 2'b01;
    #2;
    wb_rst_ni = 1'b0;
    #1;
    checkAll("async reset", 1'b0, 2'b00, 32'h0, 3'd0, 1'b0, 1'b0);
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    @(posedge wb_clk_i);
    #1;
    checkAll("reset release", 1'b1, 2'b00, 32'h0, 3'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
